// File: rtl/a4to2_event_encoder.sv
// ---------------------------------------------------------------------------
// a4to2_event_encoder
//
// Re-encodes rising edges on four one-hot strobe lines (y0..y3) into a
// 2-bit index stream {i0,i1} delivered over a valid/ready handshake. Each
// line can hold one pending event. A further edge on a line whose event is
// still pending (and not being loaded this cycle) is dropped.
//
// Parameters:
//   RR_EN      0 = fixed priority (y0 highest), 1 = round-robin arbitration
//
// Optional build macro:
//   A4TO2_OVF_FLAG_EN  when defined, ovf is a sticky lost-event flag cleared
//                      only by rst; when undefined, ovf is tied 0.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-high reset
//   y0..y3     in   event lines, codes 00..11
//   i0, i1     out  code MSB, LSB
//   out_valid  out  {i0,i1} holds a valid code
//   out_ready  in   consumer accepts the code this cycle
//   ovf        out  sticky lost-event flag
// ---------------------------------------------------------------------------
module a4to2_event_encoder #(
  parameter int RR_EN = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic y0,
  input  logic y1,
  input  logic y2,
  input  logic y3,
  output logic i0,
  output logic i1,
  output logic out_valid,
  input  logic out_ready,
  output logic ovf
);

  logic [3:0] y_vec;
  logic [3:0] y_q;
  logic [3:0] ev;
  logic [3:0] pending;
  logic [3:0] pending_next;
  logic [3:0] clr;
  logic [1:0] code_q;
  logic [1:0] last;
  logic [1:0] search_start;
  logic [1:0] winner;
  logic       load;
  logic       any_pend;

  // Returns the first set request found when scanning upward (with wrap)
  // from 'start'. Result is meaningless when req is all zero; callers gate
  // on any_pend.
  function automatic logic [1:0] pick_winner(input logic [3:0] req,
                                             input logic [1:0] start);
    logic [1:0] idx;
    logic       found;
    pick_winner = start;
    found       = 1'b0;
    for (int k = 0; k < 4; k++) begin
      idx = start + 2'(k);
      if (!found && req[idx]) begin
        pick_winner = idx;
        found       = 1'b1;
      end
    end
  endfunction

  assign y_vec    = {y3, y2, y1, y0};
  assign ev       = y_vec & ~y_q;
  assign any_pend = |pending;
  assign load     = ~out_valid | out_ready;

  // Fixed priority always scans from y0; round-robin starts just past the
  // previous winner.
  assign search_start = (RR_EN != 0) ? last + 2'd1 : 2'd0;

  always_comb begin
    winner = pick_winner(pending, search_start);
    clr    = 4'b0000;
    if (load && any_pend) begin
      clr[winner] = 1'b1;
    end
    // A new edge on the bit being loaded this cycle survives as a fresh
    // pending event.
    pending_next = ev | (pending & ~clr);
  end

  // Stage boundary: edge detect / pending capture -> output register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_q       <= 4'b0000;
      pending   <= 4'b0000;
      code_q    <= 2'b00;
      out_valid <= 1'b0;
      last      <= 2'd3;
    end else begin
      y_q     <= y_vec;
      pending <= pending_next;
      if (load) begin
        if (any_pend) begin
          code_q    <= winner;
          out_valid <= 1'b1;
          last      <= winner;
        end else begin
          out_valid <= 1'b0;
        end
      end
    end
  end

  assign i0 = code_q[1];
  assign i1 = code_q[0];

`ifdef A4TO2_OVF_FLAG_EN
  logic ovf_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (|(ev & pending & ~clr)) begin
      ovf_q <= 1'b1;
    end
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: doc/a4to2_event_encoder.md
Name: a4to2_event_encoder

Overview:
- Inverse of the 2-to-4 decoder: watches the four one-hot lines y0..y3, captures each rising edge as a pending event, and re-encodes events into the 2-bit code {i0,i1}.
- Example: y2 maps to i0=1, i1=0.
- Codes are delivered one at a time over a valid/ready handshake.
- Used where decoded strobes must be turned back into a compact index stream for a downstream consumer.

Parameters:
- RR_EN, 0, arbitration select: 0 = fixed priority (y0 highest, y3 lowest); 1 = round-robin.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  reset, asynchronous, active-high
- y0  input  1  event line 0, code 00
- y1  input  1  event line 1, code 01
- y2  input  1  event line 2, code 10
- y3  input  1  event line 3, code 11
- i0  output  1  code MSB
- i1  output  1  code LSB
- out_valid  output  1  {i0,i1} holds a valid code
- out_ready  input  1  consumer accepts the code this cycle
- ovf  output  1  sticky lost-event flag (see Optional Feature)

Behaviour:
- Single clock domain: clk. Reset rst is asynchronous and active-high.
- Reset values: i0=0, i1=0, out_valid=0, ovf=0, pending[3:0]=0, y_q[3:0]=0. The round-robin pointer last=3, so the first search starts at y0.
- Edge capture:
  - y_q registers y0..y3 every clock.
  - ev[n] = y_n & ~y_q[n].
  - A line held high produces exactly one event.
  - A line already high when reset deasserts produces one event at the first clock.
- Pending update: pending_next[n] = ev[n] | (pending[n] & ~clr[n]), where clr[n] marks the bit loaded into the output register this cycle.
- Same-bit collision: if ev[n] and clr[n] occur in the same cycle, the new event is kept (pending stays 1).
- Load condition: load = ~out_valid | out_ready.
- On load with any pending bit set:
  - Select a winner; {i0,i1} <= winner index; out_valid <= 1; clear that pending bit.
  - Fixed priority: lowest set index wins.
  - Round-robin: search starts at (last+1) mod 4 and wraps; last <= winner.
- On load with pending=0: out_valid <= 0. {i0,i1} keep their last values, which are don't-care to the consumer.
- Stall: while out_valid=1 and out_ready=0, {i0,i1} and out_valid are held stable and pending bits accumulate.
- Transfer occurs on any clock with out_valid=1 and out_ready=1. Back-to-back transfers every cycle are supported when events are pending.
- Latency: edge sampled at clock k → pending set after k → out_valid=1 with code after clock k+1, provided the output register is free or being drained.
- Lost event: ev[n]=1 while pending[n]=1 and clr[n]=0. The event is dropped (one event per line can be pending).
- Event newly arriving on the bit currently shown at the output: this is not a loss. That bit was cleared from pending when loaded.
- Reset mid-operation: all state returns to reset values immediately, regardless of clk. In-flight and pending codes are discarded.

Optional Feature:
- Macro: A4TO2_OVF_FLAG_EN.
- Defined: ovf is set on any lost event and stays 1 until rst.
- Undefined: the ovf port remains present but is tied 0, and no overflow logic is built.
- Event dropping behaviour is identical in both builds.

Test Plan:
- Reset, then pulse y2 high for 1 cycle with out_ready=1 → out_valid=1 two clocks after the sample edge, with i0=1, i1=0, for exactly 1 cycle; ovf=0.
- Hold y1 high for 10 cycles with out_ready=1 → exactly one transfer, code 01.
- RR_EN=0, out_ready=0: pulse y3,y1,y0 together, then set out_ready=1 → transfers are 00 (the code loaded while stalled, y0), then 01, then 11; code is stable during the stall.
- RR_EN=1, repeatedly pulse all four lines together, ready always 1 → codes rotate 00,01,10,11,00,...
- out_ready=0 with code 00 held; pulse y2 twice (separate edges) → second edge lost; ovf=1 with A4TO2_OVF_FLAG_EN, 0 without; after ready, only codes 00,10 are delivered.
- Assert rst asynchronously mid-stall with pending events → out_valid, i0, i1, ovf go 0 before the next clk edge; no stale codes are delivered after release.
